// File: rtl/user_trap_controller.sv
// User-mode trap sequencer: takes exceptions, interrupts and URET, then writes uepc/ucause/ustatus and redirects the PC.
// Optional build macro UTVEC_VECTORED_EN enables vectored interrupt targets when utvec mode is 2'b01.
module user_trap_controller #(
    parameter int NINT = 4
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iExc,
    input  logic [4:0]      iExcCause,
    input  logic [31:0]     iExcPC,
    input  logic [31:0]     iNextPC,
    input  logic [NINT-1:0] iIntReq,
    input  logic            iURET,
    input  logic [31:0]     iUSTATUS,
    input  logic [NINT-1:0] iUIE,
    input  logic [31:0]     iUTVEC,
    input  logic [31:0]     iUEPC,
    output logic            oCSRWe,
    output logic [6:0]      oCSRNum,
    output logic [31:0]     oCSRData,
    output logic            oFlush,
    output logic            oRedirect,
    output logic [31:0]     oTarget,
    output logic            oBusy
);

    localparam logic [6:0] CSR_USTATUS = 7'd0;
    localparam logic [6:0] CSR_UEPC    = 7'd65;
    localparam logic [6:0] CSR_UCAUSE  = 7'd66;

`ifdef UTVEC_VECTORED_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_EPC   = 3'd1,
        S_W_CAUSE = 3'd2,
        S_W_STAT  = 3'd3,
        S_REDIR   = 3'd4,
        S_R_STAT  = 3'd5,
        S_R_REDIR = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_epc;
    logic [4:0]    r_exc_code;
    logic          r_is_int;
    logic [7:0]    r_idx;

    logic [NINT-1:0] w_pend;
    logic            w_int_take;
    logic [7:0]      w_int_idx;
    logic [31:0]     w_cause;
    logic [31:0]     w_stat_trap;
    logic [31:0]     w_stat_ret;
    logic [31:0]     w_base;
    logic            w_vec_sel;
    logic [31:0]     w_vector;

    logic            w_csr_we;
    logic [6:0]      w_csr_num;
    logic [31:0]     w_csr_data;
    logic            w_flush;
    logic            w_redirect;
    logic [31:0]     w_target;

    assign w_pend     = iIntReq & iUIE;
    assign w_int_take = iUSTATUS[0] & (|w_pend);

    // Scan from the top so the lowest pending index is the one left standing.
    always_comb begin
        w_int_idx = 8'd0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_int_idx = 8'(i);
            end
        end
    end

    assign w_cause     = r_is_int ? {1'b1, 23'd0, r_idx} : {27'd0, r_exc_code};
    assign w_stat_trap = {iUSTATUS[31:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0};
    assign w_stat_ret  = {iUSTATUS[31:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]};
    assign w_base      = {iUTVEC[31:2], 2'b00};
    assign w_vec_sel   = VEC_EN & r_is_int & (iUTVEC[1:0] == 2'b01);
    assign w_vector    = w_vec_sel ? (w_base + {22'd0, r_idx, 2'b00}) : w_base;

    // State register plus the trap context captured on acceptance.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= S_IDLE;
            r_epc      <= 32'd0;
            r_exc_code <= 5'd0;
            r_is_int   <= 1'b0;
            r_idx      <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                if (iExc) begin
                    r_epc      <= iExcPC;
                    r_exc_code <= iExcCause;
                    r_is_int   <= 1'b0;
                    r_idx      <= 8'd0;
                end else if (w_int_take) begin
                    r_epc      <= iNextPC;
                    r_exc_code <= 5'd0;
                    r_is_int   <= 1'b1;
                    r_idx      <= w_int_idx;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iExc || w_int_take) begin
                    w_state_next = S_W_EPC;
                end else if (iURET) begin
                    w_state_next = S_R_STAT;
                end
            end
            S_W_EPC:   w_state_next = S_W_CAUSE;
            S_W_CAUSE: w_state_next = S_W_STAT;
            S_W_STAT:  w_state_next = S_REDIR;
            S_REDIR:   w_state_next = S_IDLE;
            S_R_STAT:  w_state_next = S_R_REDIR;
            S_R_REDIR: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_csr_we   = 1'b0;
        w_csr_num  = 7'd0;
        w_csr_data = 32'd0;
        w_flush    = 1'b0;
        w_redirect = 1'b0;
        w_target   = 32'd0;
        case (r_state)
            S_W_EPC: begin
                w_csr_we   = 1'b1;
                w_csr_num  = CSR_UEPC;
                w_csr_data = r_epc;
                w_flush    = 1'b1;
            end
            S_W_CAUSE: begin
                w_csr_we   = 1'b1;
                w_csr_num  = CSR_UCAUSE;
                w_csr_data = w_cause;
                w_flush    = 1'b1;
            end
            S_W_STAT: begin
                w_csr_we   = 1'b1;
                w_csr_num  = CSR_USTATUS;
                w_csr_data = w_stat_trap;
            end
            S_REDIR: begin
                w_redirect = 1'b1;
                w_target   = w_vector;
            end
            S_R_STAT: begin
                w_csr_we   = 1'b1;
                w_csr_num  = CSR_USTATUS;
                w_csr_data = w_stat_ret;
                w_flush    = 1'b1;
            end
            S_R_REDIR: begin
                w_redirect = 1'b1;
                w_target   = iUEPC;
            end
            default: ;
        endcase
    end

    // Outputs lag the state by one cycle so the datapath only ever sees flops.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCSRWe    <= 1'b0;
            oCSRNum   <= 7'd0;
            oCSRData  <= 32'd0;
            oFlush    <= 1'b0;
            oRedirect <= 1'b0;
            oTarget   <= 32'd0;
        end else begin
            oCSRWe    <= w_csr_we;
            oCSRNum   <= w_csr_num;
            oCSRData  <= w_csr_data;
            oFlush    <= w_flush;
            oRedirect <= w_redirect;
            oTarget   <= w_target;
        end
    end

    assign oBusy = (r_state != S_IDLE);

endmodule

// File: tb/tb_user_trap_controller.sv
// Scoreboard bench for user_trap_controller: directed cases then random events against a rule-level model.
module tb_user_trap_controller;

`ifdef UTVEC_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iExc;
    logic [4:0]  iExcCause;
    logic [31:0] iExcPC;
    logic [31:0] iNextPC;
    logic [3:0]  iIntReq;
    logic        iURET;
    logic [31:0] iUSTATUS;
    logic [3:0]  iUIE;
    logic [31:0] iUTVEC;
    logic [31:0] iUEPC;
    logic        oCSRWe;
    logic [6:0]  oCSRNum;
    logic [31:0] oCSRData;
    logic        oFlush;
    logic        oRedirect;
    logic [31:0] oTarget;
    logic        oBusy;

    user_trap_controller #(.NINT(4)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iExc(iExc), .iExcCause(iExcCause),
        .iExcPC(iExcPC), .iNextPC(iNextPC), .iIntReq(iIntReq), .iURET(iURET),
        .iUSTATUS(iUSTATUS), .iUIE(iUIE), .iUTVEC(iUTVEC), .iUEPC(iUEPC),
        .oCSRWe(oCSRWe), .oCSRNum(oCSRNum), .oCSRData(oCSRData), .oFlush(oFlush),
        .oRedirect(oRedirect), .oTarget(oTarget), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        redir;
        logic [6:0]  num;
        logic [31:0] data;
        logic        flush;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_writes = 0;
    int   n_events = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Monitor: every CSR write or redirect must match the oldest expectation, cycle included.
    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (oCSRWe || oRedirect) begin
                n_events++;
                if (oCSRWe) n_writes++;
                $display("txn cyc=%0d we=%0b num=%0d data=%h flush=%0b redir=%0b target=%h",
                         cyc, oCSRWe, oCSRNum, oCSRData, oFlush, oRedirect, oTarget);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d we=%0b redir=%0b required=none", cyc, oCSRWe, oRedirect);
                end else begin
                    exp_t e;
                    logic ok;
                    e  = sb.pop_front();
                    ok = (oRedirect == e.redir) && (oCSRWe == !e.redir) && (oFlush == e.flush) && (cyc == e.cyc);
                    if (e.redir) ok = ok && (oTarget == e.data);
                    else         ok = ok && (oCSRNum == e.num) && (oCSRData == e.data);
                    if (!ok) begin
                        errors++;
                        $display("FAIL txn_match actual: cyc=%0d redir=%0b num=%0d data=%h target=%h flush=%0b required: cyc=%0d redir=%0b num=%0d value=%h flush=%0b",
                                 cyc, oRedirect, oCSRNum, oCSRData, oTarget, oFlush, e.cyc, e.redir, e.num, e.data, e.flush);
                    end
                end
            end else begin
                checks++;
                if (oCSRNum != 7'd0 || oCSRData != 32'd0 || oFlush || oTarget != 32'd0) begin
                    errors++;
                    $display("FAIL idle_outputs cyc=%0d num=%0d data=%h flush=%0b target=%h required=all zero",
                             cyc, oCSRNum, oCSRData, oFlush, oTarget);
                end
            end
        end
    end

    task automatic push_exp(input logic redir, input logic [6:0] num, input logic [31:0] data,
                            input logic flush, input int c);
        exp_t e;
        e.redir = redir; e.num = num; e.data = data; e.flush = flush; e.cyc = c;
        sb.push_back(e);
    endtask

    // Reference model: decide what the event means, then list the CSR writes and redirect it causes.
    task automatic model(input int k, input logic exc, input logic [4:0] code, input logic [31:0] epc,
                         input logic [31:0] npc, input logic [3:0] req, input logic uret,
                         input logic [31:0] us, input logic [3:0] uie, input logic [31:0] tvec,
                         input logic [31:0] uepc);
        logic [3:0]  pend;
        logic        trap;
        logic        is_int;
        int          idx;
        logic [31:0] t_epc, t_cause, new_us, vec;
        pend   = req & uie;
        trap   = 1'b0;
        is_int = 1'b0;
        idx    = 0;
        t_epc  = 32'd0;
        t_cause = 32'd0;
        if (exc) begin
            trap = 1'b1; t_epc = epc; t_cause = 32'(code);
        end else if (us[0] && pend != 4'd0) begin
            trap = 1'b1; is_int = 1'b1; t_epc = npc;
            for (int i = 3; i >= 0; i--) if (pend[i]) idx = i;
            t_cause = 32'h8000_0000 + 32'(idx);
        end
        if (trap) begin
            new_us = (us & ~32'h11) | (us[0] ? 32'h10 : 32'h0);
            vec    = tvec & 32'hFFFF_FFFC;
            if (VEC && is_int && tvec[1:0] == 2'b01) vec = vec + 32'(4 * idx);
            push_exp(1'b0, 7'd65, t_epc, 1'b1, k + 2);
            push_exp(1'b0, 7'd66, t_cause, 1'b1, k + 3);
            push_exp(1'b0, 7'd0, new_us, 1'b0, k + 4);
            push_exp(1'b1, 7'd0, vec, 1'b0, k + 5);
        end else if (uret) begin
            new_us = (us & ~32'h11) | 32'h10 | (us[4] ? 32'h1 : 32'h0);
            push_exp(1'b0, 7'd0, new_us, 1'b1, k + 2);
            push_exp(1'b1, 7'd0, uepc, 1'b0, k + 3);
        end
    endtask

    task automatic issue(input logic exc, input logic [4:0] code, input logic [31:0] epc,
                         input logic [31:0] npc, input logic [3:0] req, input logic uret,
                         input logic [31:0] us, input logic [3:0] uie, input logic [31:0] tvec,
                         input logic [31:0] uepc);
        @(posedge iCLK); #1;
        iExc = exc; iExcCause = code; iExcPC = epc; iNextPC = npc; iIntReq = req;
        iURET = uret; iUSTATUS = us; iUIE = uie; iUTVEC = tvec; iUEPC = uepc;
        model(cyc, exc, code, epc, npc, req, uret, us, uie, tvec, uepc);
        @(posedge iCLK); #1;
        iExc = 1'b0; iURET = 1'b0; iIntReq = 4'd0;
    endtask

    task automatic wait_drain(input string name);
        repeat (6) @(posedge iCLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s pending=%0d required=0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        int w0;
        iRST_N = 1'b0; iExc = 1'b0; iExcCause = 5'd0; iExcPC = 32'd0; iNextPC = 32'd0;
        iIntReq = 4'd0; iURET = 1'b0; iUSTATUS = 32'd0; iUIE = 4'd0; iUTVEC = 32'd0; iUEPC = 32'd0;
        repeat (3) @(posedge iCLK);
        #1;
        check("reset_outputs", {oCSRWe, oCSRNum, oCSRData, oFlush, oRedirect, oTarget, oBusy} == '0,
              {24'd0, oCSRWe, oFlush, oRedirect, oBusy, 4'd0}, 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;

        issue(1, 5'd2, 32'h0040_0010, 32'h0, 4'h0, 0, 32'h1, 4'h0, 32'h0040_0200, 32'h0);
        wait_drain("exception");
        issue(0, 5'd0, 32'h0, 32'h0040_0020, 4'b0110, 0, 32'h1, 4'b0110, 32'h0040_0200, 32'h0);
        wait_drain("interrupt");
        issue(0, 5'd0, 32'h0, 32'h0040_0020, 4'b0110, 0, 32'h1, 4'b0110, 32'h0040_0201, 32'h0);
        wait_drain("vectored_int");
        issue(1, 5'd5, 32'h0040_0030, 32'h0, 4'b0110, 0, 32'h1, 4'b0110, 32'h0040_0201, 32'h0);
        wait_drain("vectored_exc");
        issue(0, 5'd0, 32'h0, 32'h0040_0040, 4'b1000, 0, 32'h1, 4'b1000, 32'h0040_0202, 32'h0);
        wait_drain("mode_1x");

        w0 = n_events;
        issue(0, 5'd0, 32'h0, 32'h0040_0020, 4'b1111, 0, 32'h0, 4'b1111, 32'h0040_0200, 32'h0);
        wait_drain("masked");
        check("masked_quiet", n_events == w0 && !oBusy, 32'(n_events - w0), 32'd0);

        issue(0, 5'd0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 4'h0, 32'h0040_0200, 32'h0040_0014);
        wait_drain("uret");
        issue(1, 5'd3, 32'h0040_0050, 32'h0, 4'h0, 1, 32'h1, 4'h0, 32'h0040_0200, 32'h0040_0014);
        wait_drain("exc_and_uret");

        // Second exception lands while the first is in W_CAUSE and must be ignored.
        w0 = n_writes;
        issue(1, 5'd4, 32'h0040_0060, 32'h0, 4'h0, 0, 32'h1, 4'h0, 32'h0040_0200, 32'h0);
        @(posedge iCLK); #1;
        iExc = 1'b1; iExcCause = 5'd7; iExcPC = 32'hDEAD_0000;
        @(posedge iCLK); #1;
        iExc = 1'b0;
        wait_drain("busy_exc");
        check("busy_write_count", n_writes - w0 == 3, 32'(n_writes - w0), 32'd3);

        // Reset asserted while the controller sits in W_CAUSE.
        issue(1, 5'd6, 32'h0040_0070, 32'h0, 4'h0, 0, 32'h1, 4'h0, 32'h0040_0200, 32'h0);
        @(posedge iCLK); #7;
        iRST_N = 1'b0;
        sb.delete();
        #1;
        check("reset_mid_seq", {oCSRWe, oCSRNum, oCSRData, oFlush, oRedirect, oTarget, oBusy} == '0,
              {24'd0, oCSRWe, oFlush, oRedirect, oBusy, 4'd0}, 32'd0);
        @(posedge iCLK); @(posedge iCLK); #3;
        iRST_N = 1'b1;
        w0 = n_events;
        repeat (6) @(posedge iCLK);
        #1;
        check("reset_no_more", n_events == w0 && !oBusy, 32'(n_events - w0), 32'd0);

        for (int t = 0; t < 60; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            issue(r < 3, 5'($urandom_range(0, 31)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  r == 0 || r == 3 || r == 4, $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom);
            wait_drain("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
